cam_ctrl: RTL
=============

# cam_ctrl

Host-side controller for the CAM: the initiator end of the CAM write/mask/search interface. Accepts commands from upstream logic over a valid/ready port, drives the CAM's data, address and mask inputs, waits for `hit`, captures `data_out`/`addr_out`, acknowledges with `data_valid`, and returns one response per command. Sits between the CAM and the lookup client; it replaces bench-style driving with synthesizable sequencing and a miss timeout.

## Interface
- `CAM_DW`, 32, CAM data/key width
- `CAM_MW`, 3, mask and strobe width
- `CAM_AW`, 8, CAM address width
- `TIMEOUT`, 16, search cycles before a miss is declared (legal range 2..255)

- `clk` in 1 – single clock, rising edge
- `rst_n` in 1 – asynchronous, active-low reset
- `cmd_valid` in 1 – command present
- `cmd_ready` out 1 – controller idle, command accepted this cycle if `cmd_valid`
- `cmd_op` in 2 – 00 write, 01 mask, 10 lookup, 11 reserved
- `cmd_data` in CAM_DW – write data or search key
- `cmd_addr` in CAM_AW – write address
- `cmd_mask` in CAM_MW – mask value
- `cmd_strb` in CAM_MW – mask strobe
- `rsp_valid` out 1 – response present
- `rsp_ready` in 1 – upstream accepts response
- `rsp_hit` out 1 – lookup hit
- `rsp_err` out 1 – reserved opcode
- `rsp_data` out CAM_DW – hit data (lookup) / written data (write) / 0 otherwise
- `rsp_addr` out CAM_AW – hit address (lookup) / written address (write) / 0 otherwise
- `data_in` out CAM_DW, `addr_in` out CAM_AW, `input_valid` out 1 – CAM write/key port
- `mask_in` out CAM_MW, `mask_strb` out CAM_MW, `mask_en` out 1 – CAM mask port
- `data_out` in CAM_DW, `addr_out` in CAM_AW, `hit` in 1 – CAM result port
- `data_valid` out 1 – result acknowledge to CAM
- `stat_hits`, `stat_misses` out 16 each – lookup counters (see Configuration)

## Operation
- States: IDLE, WRITE, MASK, SEARCH, CAPT, RESP.
- IDLE: `cmd_ready`=1 only here. On accept, register all `cmd_*` fields; op 00→WRITE, 01→MASK, 10→SEARCH, 11→RESP with `rsp_err`=1.
- WRITE: `input_valid`=1 for exactly one cycle with registered `data_in`/`addr_in`; →RESP, `rsp_hit`=0, `rsp_data`/`rsp_addr` = written values.
- MASK: `mask_in`/`mask_strb` load registered values (held until next mask command); `mask_en` is a level: set when `cmd_strb`≠0, cleared when `cmd_strb`=0; →RESP, `rsp_hit`=0.
- SEARCH: `data_in` = key, `input_valid`=0; counter starts at 0 and increments each cycle. `hit`=1 sampled →CAPT. Counter reaching TIMEOUT−1 without hit →RESP with `rsp_hit`=0, data/addr 0. Hit on the final count cycle wins over timeout.
- CAPT: register `data_out`/`addr_out` into `rsp_data`/`rsp_addr`, `data_valid`=1 for this single cycle, `rsp_hit`=1; →RESP.
- RESP: `rsp_valid`=1, all `rsp_*` stable until `rsp_valid && rsp_ready`; then →IDLE. No new command accepted while a response is pending.
- `data_in`/`addr_in` hold last driven value between commands.

## Timing
- All outputs registered. Reset values: every output 0, state IDLE, counters 0; `cmd_ready` becomes 1 the first cycle after reset release.
- Command accepted at edge N: write/mask → `rsp_valid` at N+2; lookup with `hit` seen in first SEARCH cycle (N+1) → `data_valid` in N+2, `rsp_valid` at N+3; miss → `rsp_valid` at N+1+TIMEOUT.
- `rsp_ready` high when `rsp_valid` rises: `cmd_ready` returns next cycle (one command per ≥3 cycles).
- Reset asserted mid-operation: immediate return to IDLE, `mask_en` cleared, pending response discarded, `data_valid`/`input_valid` drop asynchronously.

## Configuration
- `CAM_CTRL_STATS_EN` defined: `stat_hits`/`stat_misses` count completed lookups (increment on RESP handshake), saturate at 0xFFFF, clear on reset.
- Not defined: counter logic absent, both ports tied to 0.

## Test plan
- Write 0xFFFF_FFFF to addr 0x01 → `input_valid` one cycle with those values, response `rsp_hit`=0, `rsp_addr`=0x01 at N+2.
- Mask cmd mask=3'b111 strb=3'b111 → `mask_en`=1 held; then strb=0 → `mask_en`=0, `mask_in` retains 3'b111.
- Lookup key 0xFFFF_FFFF, CAM model raises `hit` with addr 0x01 → one-cycle `data_valid`, response hit=1, data 0xFFFF_FFFF, addr 0x01 at N+3.
- Lookup with `hit` never asserted, TIMEOUT=16 → response hit=0, data/addr 0 at N+17; `hit` on cycle 16 only → hit=1.
- `rsp_ready` held low 5 cycles → `rsp_*` stable, `cmd_ready`=0, command not accepted; op 11 → `rsp_err`=1.
- Reset pulse during SEARCH → all outputs 0, IDLE; with `CAM_CTRL_STATS_EN`, 3 hits + 2 misses → 3/2, counters saturate at 0xFFFF.

Source files
------------

// File: rtl/cam_ctrl_if.sv
// rtl/cam_ctrl_if.sv - upstream command/response port of the CAM host controller
interface cam_ctrl_if #(
    parameter int CAM_DW = 32,
    parameter int CAM_MW = 3,
    parameter int CAM_AW = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CAM_DW-1:0] cmd_data;
    logic [CAM_AW-1:0] cmd_addr;
    logic [CAM_MW-1:0] cmd_mask;
    logic [CAM_MW-1:0] cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_err;
    logic [CAM_DW-1:0] rsp_data;
    logic [CAM_AW-1:0] rsp_addr;

    // master: lookup client issuing commands; slave: cam_ctrl
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_addr, cmd_mask, cmd_strb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_err, rsp_data, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_addr, cmd_mask, cmd_strb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_err, rsp_data, rsp_addr
    );
endinterface

// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - CAM host controller: write/mask/search sequencing with miss timeout
// Optional lookup statistics counters enabled by defining CAM_CTRL_STATS_EN.
module cam_ctrl #(
    parameter int CAM_DW  = 32,
    parameter int CAM_MW  = 3,
    parameter int CAM_AW  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cam_ctrl_if.slave         host,
    output logic [CAM_DW-1:0] data_in,
    output logic [CAM_AW-1:0] addr_in,
    output logic              input_valid,
    output logic [CAM_MW-1:0] mask_in,
    output logic [CAM_MW-1:0] mask_strb,
    output logic              mask_en,
    input  logic [CAM_DW-1:0] data_out,
    input  logic [CAM_AW-1:0] addr_out,
    input  logic              hit,
    output logic              data_valid,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_MASK   = 3'd2;
    localparam logic [2:0] ST_SEARCH = 3'd3;
    localparam logic [2:0] ST_CAPT   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_MASK   = 2'b01;
    localparam logic [1:0] OP_LOOKUP = 2'b10;

    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CAM_DW-1:0] cmd_data_q, cmd_data_d;
    logic [CAM_AW-1:0] cmd_addr_q, cmd_addr_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CAM_DW-1:0] rsp_data_q, rsp_data_d;
    logic [CAM_AW-1:0] rsp_addr_q, rsp_addr_d;

    logic [CAM_DW-1:0] data_in_q, data_in_d;
    logic [CAM_AW-1:0] addr_in_q, addr_in_d;
    logic              input_valid_q, input_valid_d;
    logic [CAM_MW-1:0] mask_in_q, mask_in_d;
    logic [CAM_MW-1:0] mask_strb_q, mask_strb_d;
    logic              mask_en_q, mask_en_d;
    logic              data_valid_q, data_valid_d;

    logic              cmd_fire;
    logic              rsp_fire;

    assign cmd_fire = (state_q == ST_IDLE) && cmd_ready_q && host.cmd_valid;
    assign rsp_fire = (state_q == ST_RESP) && rsp_valid_q && host.rsp_ready;

    // Every output is a flop; each one is loaded on the transition into the
    // state where it must be visible, so the next-state decision drives it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_data_d    = cmd_data_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_err_d     = rsp_err_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;
        data_in_d     = data_in_q;
        addr_in_d     = addr_in_q;
        input_valid_d = 1'b0;
        mask_in_d     = mask_in_q;
        mask_strb_d   = mask_strb_q;
        mask_en_d     = mask_en_q;
        data_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_fire) begin
                    cmd_ready_d = 1'b0;
                    cmd_data_d  = host.cmd_data;
                    cmd_addr_d  = host.cmd_addr;
                    rsp_hit_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    rsp_addr_d  = '0;
                    case (host.cmd_op)
                        OP_WRITE: begin
                            state_d       = ST_WRITE;
                            data_in_d     = host.cmd_data;
                            addr_in_d     = host.cmd_addr;
                            input_valid_d = 1'b1;
                        end
                        OP_MASK: begin
                            state_d     = ST_MASK;
                            mask_in_d   = host.cmd_mask;
                            mask_strb_d = host.cmd_strb;
                            mask_en_d   = |host.cmd_strb;
                        end
                        OP_LOOKUP: begin
                            state_d   = ST_SEARCH;
                            data_in_d = host.cmd_data;
                            cnt_d     = '0;
                        end
                        default: begin
                            state_d     = ST_RESP;
                            rsp_err_d   = 1'b1;
                            rsp_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cmd_data_q;
                rsp_addr_d  = cmd_addr_q;
            end
            ST_MASK: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_SEARCH: begin
                // A hit on the last count cycle still beats the timeout.
                if (hit) begin
                    state_d      = ST_CAPT;
                    data_valid_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CAPT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b1;
                rsp_data_d  = data_out;
                rsp_addr_d  = addr_out;
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_hit_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    rsp_addr_d  = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_data_q    <= '0;
            cmd_addr_q    <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            data_in_q     <= '0;
            addr_in_q     <= '0;
            input_valid_q <= 1'b0;
            mask_in_q     <= '0;
            mask_strb_q   <= '0;
            mask_en_q     <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_data_q    <= cmd_data_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            data_in_q     <= data_in_d;
            addr_in_q     <= addr_in_d;
            input_valid_q <= input_valid_d;
            mask_in_q     <= mask_in_d;
            mask_strb_q   <= mask_strb_d;
            mask_en_q     <= mask_en_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_hit   = rsp_hit_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_addr  = rsp_addr_q;

    assign data_in     = data_in_q;
    assign addr_in     = addr_in_q;
    assign input_valid = input_valid_q;
    assign mask_in     = mask_in_q;
    assign mask_strb   = mask_strb_q;
    assign mask_en     = mask_en_q;
    assign data_valid  = data_valid_q;

`ifdef CAM_CTRL_STATS_EN
    logic        lookup_q, lookup_d;
    logic [15:0] hits_q, hits_d;
    logic [15:0] misses_q, misses_d;

    // Counted when the lookup response is handed over, not when the CAM answers.
    always_comb begin
        lookup_d = lookup_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        if (cmd_fire) begin
            lookup_d = (host.cmd_op == OP_LOOKUP);
        end
        if (rsp_fire && lookup_q) begin
            if (rsp_hit_q) begin
                hits_d = (hits_q != 16'hFFFF) ? hits_q + 16'd1 : hits_q;
            end else begin
                misses_d = (misses_q != 16'hFFFF) ? misses_q + 16'd1 : misses_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_q <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            lookup_q <= lookup_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
